// File: rtl/pipe_hazard_ctrl.sv
// Central hazard and sequencing controller for the 5-stage pipeline.
// It drives the pipeline register enables and flushes, EX operand forwarding, and the data-memory handshake.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             uses_rs1_ID,
    input  logic             uses_rs2_ID,
    input  logic [4:0]       rs1_EX,
    input  logic [4:0]       rs2_EX,
    input  logic [4:0]       rd_EX,
    input  logic             MemRead_EX,
    input  logic             branch_taken_EX,
    input  logic [4:0]       rd_MEM,
    input  logic             RegWrite_MEM,
    input  logic             MemAccess_MEM,
    input  logic [4:0]       rd_WB,
    input  logic             RegWrite_WB,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             IF_ID_en,
    output logic             ID_EX_en,
    output logic             EX_MEM_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             MEM_WB_bubble,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, ERROR} state_t;

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT_CYCLES);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       mem_stall;
    logic       load_use;
    logic       stall_evt;
    logic       flush_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + CNT_W'(1);
    endfunction

    // The MEM-stage result is newer than the WB-stage result, so MEM is checked first.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wr_mem, input logic [4:0] rd_m,
                                           input logic       wr_wb,  input logic [4:0] rd_w);
        if (wr_mem && rd_m != 5'd0 && rd_m == rs) return 2'b10;
        if (wr_wb && rd_w != 5'd0 && rd_w == rs)  return 2'b01;
        return 2'b00;
    endfunction

    assign fwdA = fwd_sel(rs1_EX, RegWrite_MEM, rd_MEM, RegWrite_WB, rd_WB);
    assign fwdB = fwd_sel(rs2_EX, RegWrite_MEM, rd_MEM, RegWrite_WB, rd_WB);

    assign load_use = MemRead_EX && (rd_EX != 5'd0) &&
                      ((uses_rs1_ID && rs1_ID == rd_EX) || (uses_rs2_ID && rs2_ID == rd_EX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            mem_error <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            mem_error <= mem_error | (state_nxt == ERROR);
            if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
            if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        mem_stall     = 1'b0;
        dmem_req      = 1'b0;
        pc_en         = 1'b1;
        IF_ID_en      = 1'b1;
        ID_EX_en      = 1'b1;
        EX_MEM_en     = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_flush   = 1'b0;
        MEM_WB_bubble = 1'b0;
        stall_evt     = 1'b0;
        flush_evt     = 1'b0;

        case (state)
            IDLE: begin
                dmem_req = MemAccess_MEM;
                if (MemAccess_MEM && !dmem_ready) begin
                    mem_stall = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = 8'd1;
                end
            end
            MEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_nxt = IDLE;
                    wait_nxt  = 8'd0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt == TIMEOUT_W) state_nxt = ERROR;
                    else                       wait_nxt  = wait_cnt + 8'd1;
                end
            end
            default: state_nxt = ERROR;
        endcase

        // A frozen pipeline suppresses branch flushes; the branch stays in EX and flushes on release.
        if (state == ERROR || mem_stall) begin
            pc_en         = 1'b0;
            IF_ID_en      = 1'b0;
            ID_EX_en      = 1'b0;
            EX_MEM_en     = 1'b0;
            MEM_WB_bubble = 1'b1;
        end else if (branch_taken_EX) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            IF_ID_en    = 1'b0;
            ID_EX_flush = 1'b1;
        end

        stall_evt = (state != ERROR) && (mem_stall || (load_use && !branch_taken_EX));
        flush_evt = (state != ERROR) && !mem_stall && branch_taken_EX;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a queue-and-counter reference model predicts every cycle's outputs,
// and a negedge monitor compares the DUT against those predictions.
module tb_pipe_hazard_ctrl;
    localparam int  TO      = 4;
    localparam int  CW      = 6;
    localparam longint CMAX = (64'd1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
    logic uses_rs1_ID, uses_rs2_ID, MemRead_EX, branch_taken_EX;
    logic RegWrite_MEM, MemAccess_MEM, RegWrite_WB, dmem_ready;
    logic dmem_req, pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, IF_ID_flush, ID_EX_flush, MEM_WB_bubble;
    logic [1:0] fwdA, fwdB;
    logic mem_error;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX), .MemRead_EX(MemRead_EX),
        .branch_taken_EX(branch_taken_EX), .rd_MEM(rd_MEM), .RegWrite_MEM(RegWrite_MEM),
        .MemAccess_MEM(MemAccess_MEM), .rd_WB(rd_WB), .RegWrite_WB(RegWrite_WB),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req), .pc_en(pc_en), .IF_ID_en(IF_ID_en),
        .ID_EX_en(ID_EX_en), .EX_MEM_en(EX_MEM_en), .IF_ID_flush(IF_ID_flush),
        .ID_EX_flush(ID_EX_flush), .MEM_WB_bubble(MEM_WB_bubble), .fwdA(fwdA), .fwdB(fwdB),
        .mem_error(mem_error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
        logic u1, u2, mem_rd, br, wr_mem, mem_acc, wr_wb, ready;
    } in_t;

    typedef struct {
        logic [7:0] ctrl;
        logic [1:0] fa, fb;
        logic       err;
        longint     stall, flush;
    } exp_t;

    in_t    s;
    exp_t   q[$];
    int     n_tests = 0;
    int     n_fail = 0;

    // Reference model: error flag, number of cycles the current memory access has been pending, statistics.
    bit     m_err;
    int     m_wait;
    longint m_stall, m_flush;

    function automatic void clear_in();
        s = '{default: '0};
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (s.wr_mem && s.rd_mem != 0 && s.rd_mem == rs) return 2'b10;
        if (s.wr_wb && s.rd_wb != 0 && s.rd_wb == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        bit ms, frozen, lu, br, req, hold_front;
        ms     = !m_err && !s.ready && (m_wait > 0 || s.mem_acc);
        req    = !m_err && (m_wait > 0 || s.mem_acc);
        frozen = m_err || ms;
        lu     = s.mem_rd && s.rd_ex != 0 &&
                 ((s.u1 && s.rs1_id == s.rd_ex) || (s.u2 && s.rs2_id == s.rd_ex));
        br     = s.br && !frozen;
        hold_front = frozen || (lu && !br);
        e.ctrl  = {req, !hold_front, !hold_front, !frozen, !frozen, br, br || (lu && !frozen), frozen};
        e.fa    = ref_fwd(s.rs1_ex);
        e.fb    = ref_fwd(s.rs2_ex);
        e.err   = m_err;
        e.stall = m_stall;
        e.flush = m_flush;
        return e;
    endfunction

    function automatic void model_advance(input exp_t e);
        bit stalled_now, flushed_now;
        stalled_now = !m_err && !e.ctrl[6];
        flushed_now = e.ctrl[2];
        if (!m_err) begin
            if (m_wait == 0) begin
                if (s.mem_acc && !s.ready) m_wait = 1;
            end else if (s.ready) m_wait = 0;
            else if (m_wait == TO) m_err = 1;
            else m_wait++;
        end
        if (stalled_now && m_stall < CMAX) m_stall++;
        if (flushed_now && m_flush < CMAX) m_flush++;
    endfunction

    function automatic void model_reset();
        m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    endfunction

    task automatic drive_inputs();
        rs1_ID = s.rs1_id; rs2_ID = s.rs2_id; uses_rs1_ID = s.u1; uses_rs2_ID = s.u2;
        rs1_EX = s.rs1_ex; rs2_EX = s.rs2_ex; rd_EX = s.rd_ex; MemRead_EX = s.mem_rd;
        branch_taken_EX = s.br; rd_MEM = s.rd_mem; RegWrite_MEM = s.wr_mem;
        MemAccess_MEM = s.mem_acc; rd_WB = s.rd_wb; RegWrite_WB = s.wr_wb; dmem_ready = s.ready;
    endtask

    // One cycle of stimulus; do_reset raises the async reset between clock edges.
    task automatic step(input bit do_reset);
        exp_t e;
        @(posedge clk);
        #1;
        drive_inputs();
        if (do_reset) begin
            #1 reset = 1'b1;
            model_reset();
            e = model_eval();
            q.push_back(e);
        end else begin
            reset = 1'b0;
            e = model_eval();
            q.push_back(e);
            model_advance(e);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ctrl{req,pc,ifid,idex,exmem,ifflush,idflush,bubble}",
                {56'd0, dmem_req, pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, IF_ID_flush, ID_EX_flush,
                 MEM_WB_bubble}, {56'd0, e.ctrl});
            chk("fwdA", {62'd0, fwdA}, {62'd0, e.fa});
            chk("fwdB", {62'd0, fwdB}, {62'd0, e.fb});
            chk("mem_error", {63'd0, mem_error}, {63'd0, e.err});
            chk("stall_cnt", {58'd0, stall_cnt}, e.stall);
            chk("flush_cnt", {58'd0, flush_cnt}, e.flush);
        end
    end

    initial begin
        int err_age;
        clear_in();
        drive_inputs();
        model_reset();
        step(1);

        // load-use hazard, then release
        s.mem_rd = 1; s.rd_ex = 5; s.rs1_id = 5; s.u1 = 1;
        step(0);
        clear_in(); step(0);

        // forwarding priority and x0
        s.wr_mem = 1; s.rd_mem = 3; s.wr_wb = 1; s.rd_wb = 3; s.rs1_ex = 3; s.rs2_ex = 0;
        step(0);
        s.rd_mem = 0; step(0);
        clear_in();

        // memory wait of three cycles
        s.mem_acc = 1;
        repeat (3) step(0);
        s.ready = 1; step(0);
        clear_in(); step(0);

        // branch held in EX during a memory stall
        s.mem_acc = 1; s.br = 1;
        repeat (2) step(0);
        s.ready = 1; step(0);
        clear_in(); step(0);

        // timeout into ERROR, then reset
        s.mem_acc = 1; s.br = 1; s.mem_rd = 1; s.rd_ex = 2; s.rs2_id = 2; s.u2 = 1;
        repeat (8) step(0);
        clear_in(); step(1);
        step(0);

        // async reset while stalled
        s.mem_acc = 1;
        repeat (2) step(0);
        step(1);
        clear_in(); step(0);

        // counter saturation
        s.mem_rd = 1; s.rd_ex = 7; s.rs1_id = 7; s.u1 = 1;
        repeat (70) step(0);
        clear_in(); s.br = 1;
        repeat (70) step(0);
        clear_in(); step(1);

        err_age = 0;
        for (int i = 0; i < 1500; i++) begin
            s.rs1_id = 5'($urandom_range(0, 3)); s.rs2_id = 5'($urandom_range(0, 3));
            s.rs1_ex = 5'($urandom_range(0, 3)); s.rs2_ex = 5'($urandom_range(0, 3));
            s.rd_ex  = 5'($urandom_range(0, 3)); s.rd_mem = 5'($urandom_range(0, 3));
            s.rd_wb  = 5'($urandom_range(0, 3));
            s.u1 = 1'($urandom_range(0, 1)); s.u2 = 1'($urandom_range(0, 1));
            s.mem_rd = ($urandom_range(0, 99) < 50);
            s.br = ($urandom_range(0, 99) < 15);
            s.wr_mem = 1'($urandom_range(0, 1)); s.wr_wb = 1'($urandom_range(0, 1));
            s.mem_acc = ($urandom_range(0, 99) < 40);
            s.ready = ($urandom_range(0, 99) < ((i >= 1000) ? 15 : 70));
            err_age = m_err ? err_age + 1 : 0;
            step((err_age >= 3) || ($urandom_range(0, 299) == 0));
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage 64-bit pipeline.
- Generates the enable and flush controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Selects EX-stage operand forwarding.
- Runs the data-memory req/ready handshake FSM, with timeout and stall/flush statistics.
- Sits beside the datapath; all pipeline registers take their enable/flush from this block.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in MEM_WAIT before declaring a memory error (1..255).
- CNT_W, 32: width of the saturating stall and flush counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- rs1_ID, rs2_ID  in  5  source registers in ID.
- uses_rs1_ID, uses_rs2_ID  in  1  ID instruction reads rs1/rs2.
- rs1_EX, rs2_EX  in  5  source registers in EX.
- rd_EX  in  5  destination in EX.
- MemRead_EX  in  1  EX instruction is a load.
- branch_taken_EX  in  1  EX resolved a taken branch or jump.
- rd_MEM  in  5  destination in MEM.
- RegWrite_MEM  in  1  MEM instruction writes the register file.
- MemAccess_MEM  in  1  MEM instruction is a load or store.
- rd_WB  in  5  destination in WB.
- RegWrite_WB  in  1  WB instruction writes the register file.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data memory request.
- pc_en  out  1  PC update enable.
- IF_ID_en, ID_EX_en, EX_MEM_en  out  1  register load enables.
- IF_ID_flush, ID_EX_flush  out  1  load a bubble (all control bits 0).
- MEM_WB_bubble  out  1  MEM/WB captures RegWrite=0, MemtoReg=0.
- fwdA, fwdB  out  2  00 = regfile, 10 = EX/MEM ALUResult, 01 = MEM/WB writeback value.
- mem_error  out  1  sticky timeout flag.
- stall_cnt, flush_cnt  out  CNT_W  saturating statistics.

Behaviour:
- FSM states: IDLE, MEM_WAIT, ERROR.
  - Registered: state, wait counter (8 bits), mem_error, stall_cnt, flush_cnt.
  - Reset (async): state=IDLE, wait=0, mem_error=0, counters=0.
  - All remaining outputs are combinational from state and inputs; no added latency.
- IDLE:
  - dmem_req = MemAccess_MEM.
  - If MemAccess_MEM && !dmem_ready: next state MEM_WAIT, wait=1, and this cycle is treated as a memory stall.
  - Otherwise stay in IDLE.
- MEM_WAIT:
  - dmem_req=1.
  - On dmem_ready: go to IDLE, wait=0. This cycle is not a stall; the pipeline advances.
  - Else if wait==TIMEOUT_CYCLES: go to ERROR, set mem_error=1.
  - Else wait increments.
- ERROR:
  - pc_en and all *_en = 0, MEM_WB_bubble=1, dmem_req=0.
  - Held until reset.
- Memory stall (highest priority):
  - pc_en=0, IF_ID_en=0, ID_EX_en=0, EX_MEM_en=0, MEM_WB_bubble=1.
  - No flushes, even if branch_taken_EX=1. EX is frozen, so the branch re-presents and flushes when the stall releases.
- Load-use stall (no memory stall):
  - Condition: MemRead_EX && rd_EX!=0 && ((uses_rs1_ID && rs1_ID==rd_EX) || (uses_rs2_ID && rs2_ID==rd_EX)).
  - pc_en=0, IF_ID_en=0, ID_EX_flush=1, all other enables 1.
  - Exactly 1 cycle per hazard.
- Taken branch (no memory stall):
  - IF_ID_flush=1, ID_EX_flush=1, pc_en=1.
  - Overrides load-use: the ID instruction is discarded anyway.
- Default: all enables 1, flushes 0, MEM_WB_bubble=0.
- Forwarding (evaluated per operand, same for B with rs2_EX):
  - fwdA=10 if RegWrite_MEM && rd_MEM!=0 && rd_MEM==rs1_EX.
  - Else 01 if RegWrite_WB && rd_WB!=0 && rd_WB==rs1_EX.
  - Else 00.
  - MEM match wins over WB match. Register x0 never forwards.
- stall_cnt:
  - +1 each cycle with a memory or load-use stall, excluding ERROR cycles.
  - Saturates at all-ones.
- flush_cnt:
  - +1 each cycle a taken-branch flush is issued.
  - Saturates at all-ones.
- Reset mid-MEM_WAIT: immediate return to IDLE; dmem_req follows MemAccess_MEM. Any transaction left outstanding at the memory is the memory's responsibility to drop.

Test Plan:
- Load-use: MemRead_EX=1, rd_EX=5, rs1_ID=5, uses_rs1_ID=1 -> exactly one cycle of pc_en=0, IF_ID_en=0, ID_EX_flush=1; stall_cnt=1; next cycle all enables 1.
- Forwarding: RegWrite_MEM=1, rd_MEM=3; RegWrite_WB=1, rd_WB=3; rs1_EX=3, rs2_EX=0 -> fwdA=10, fwdB=00. Repeat with rd_MEM=0 -> fwdA=01.
- Memory wait: MemAccess_MEM=1, dmem_ready low 3 cycles then high -> dmem_req=1 for 4 cycles; 3 stall cycles with EX_MEM_en=0 and MEM_WB_bubble=1; stall_cnt=3; state returns to IDLE.
- Branch during memory stall: branch_taken_EX=1 while in MEM_WAIT -> no flush until the dmem_ready cycle, then IF_ID_flush=ID_EX_flush=1; flush_cnt=1.
- Timeout: TIMEOUT_CYCLES=4, dmem_ready held 0 -> mem_error=1 after 4 MEM_WAIT cycles; all enables 0 thereafter. Assert reset -> mem_error=0, state IDLE.
- Async reset mid-stall, asserted between clock edges -> counters 0 and outputs at defaults before the next clk edge.
